// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, beat counting
// and the byte-lane selection used when capturing read data.
package lsu_pkg;

    localparam int BEATS = 4;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDLAST,
        RESP
    } state_e;

    // Read data arrives one cycle after its strobe, so RD captures the previous
    // beat's lane while RDLAST captures the lane of the final beat itself.
    function automatic logic [CNT_W-1:0] cap_lane(input state_e st, input logic [CNT_W-1:0] k);
        return (st == RDLAST) ? k : k - CNT_W'(1);
    endfunction

endpackage

// File: rtl/load_store_unit_format.sv
// Turns the captured read bytes into the load result: zero/sign-extended byte
// or little-endian word.
module lsu_load_format
    import lsu_pkg::*;
#(
    parameter int N      = 32,
    parameter int DATA_W = 8
) (
    input  logic [BEATS-1:0][DATA_W-1:0] bytes_i,
    input  logic                         byte_i,
    input  logic                         signed_i,
    output logic [N-1:0]                 data_o
);

    always_comb begin
        data_o = N'(bytes_i);
        if (byte_i) begin
            data_o = {{(N-DATA_W){signed_i & bytes_i[0][DATA_W-1]}}, bytes_i[0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage sequencer: runs one load/store as 1 or 4 byte beats against a
// byte-wide memory and returns a single response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N      = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic              req_byte_i,
    input  logic              req_signed_i,
    input  logic [N-1:0]      req_addr_i,
    input  logic [N-1:0]      req_wdata_i,
    output logic              resp_valid_o,
    output logic [N-1:0]      resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             k_q, k_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [BEATS-1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic [BEATS-1:0][DATA_W-1:0] bytes_q, bytes_d;
    logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;
    logic                         byte_q, byte_d;
    logic                         signed_q, signed_d;
    logic                         write_q, write_d;
    logic                         err_q, err_d;
    logic [CNT_W-1:0]             last_k;
    logic                         misalign;
    logic [N-1:0]                 load_data;
    logic                         unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[N-1:ADDR_W];
    assign last_k   = byte_q ? '0 : CNT_W'(BEATS-1);
    assign misalign = !req_byte_i && (req_addr_i[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        bytes_d     = bytes_q;
        mem_wdata_d = mem_wdata_q;
        byte_d      = byte_q;
        signed_d    = signed_q;
        write_d     = write_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    byte_d   = req_byte_i;
                    signed_d = req_signed_i;
                    write_d  = req_write_i;
                    err_d    = misalign;
                    if (misalign) begin
                        state_d = RESP;
                    end else begin
                        // Address/counter only move for real beats so mem_addr_o holds otherwise.
                        addr_d  = req_addr_i[ADDR_W-1:0];
                        wdata_d = req_wdata_i;
                        k_d     = '0;
                        state_d = req_write_i ? WR : RD;
                        if (req_write_i) mem_wdata_d = req_wdata_i[DATA_W-1:0];
                    end
                end
            end
            WR: begin
                if (k_q == last_k) begin
                    state_d = RESP;
                end else begin
                    k_d         = k_q + CNT_W'(1);
                    mem_wdata_d = wdata_q[k_q + CNT_W'(1)];
                end
            end
            RD: begin
                if (k_q != '0) bytes_d[cap_lane(state_q, k_q)] = mem_rdata_i;
                if (k_q == last_k) state_d = RDLAST;
                else               k_d     = k_q + CNT_W'(1);
            end
            RDLAST: begin
                bytes_d[cap_lane(state_q, k_q)] = mem_rdata_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bytes_q     <= '0;
            mem_wdata_q <= '0;
            byte_q      <= 1'b0;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bytes_q     <= bytes_d;
            mem_wdata_q <= mem_wdata_d;
            byte_q      <= byte_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            err_q       <= err_d;
        end
    end

    lsu_load_format #(.N(N), .DATA_W(DATA_W)) u_fmt (
        .bytes_i  (bytes_q),
        .byte_i   (byte_q),
        .signed_i (signed_q),
        .data_o   (load_data)
    );

    assign req_ready_o  = (state_q == IDLE);
    assign mem_we_o     = (state_q == WR);
    assign mem_re_o     = (state_q == RD);
    assign mem_addr_o   = addr_q + ADDR_W'(k_q);
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_valid_o = (state_q == RESP);
    assign resp_err_o   = resp_valid_o & err_q;
    assign resp_rdata_o = (resp_valid_o && !write_q && !err_q) ? load_data : '0;

endmodule
